usart_transmitter: RTL and testbench

Transmit half of USART0: accepts bytes from the register bus, serialises them onto `sout` as asynchronous frames (start, 5–9 data bits LSB first, optional parity, 1–2 stop bits), and raises UDRE/TXC status. Sits beside the receiver inside the USART0 wrapper, shares its frame configuration (`cs`, `upmn`, `u2xn`), and is paced by the same oversampling baud tick.

---
 rtl/usart_pkg.sv | 56 +++++
 rtl/usart_transmitter_tx_bit_timer.sv | 48 ++++
 rtl/usart_transmitter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_usart_transmitter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// ---------------------------------------------------------------------------
// usart_pkg
// Shared definitions for the USART0 transmit and receive halves.
//   - tx_state_t       : transmit shift FSM state encoding
//   - UDR_ADDR         : data register address (0xC6)
//   - UCSRA_ADDR       : control/status register A address (0xC0)
//   - TXC_BIT          : bit position of TXC inside UCSRA
//   - CS_*             : character-size codes carried on the 'cs' input
//   - UPM_*            : parity-mode codes carried on the 'upmn' input
//   - TICKS_*_MAX      : last oversample tick index of a bit period
//   - char_bits()      : maps a 'cs' code to a number of data bits
// ---------------------------------------------------------------------------
package usart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP1  = 3'd4,
      TX_STOP2  = 3'd5
   } tx_state_t;

   localparam logic [7:0] UDR_ADDR   = 8'hC6;
   localparam logic [7:0] UCSRA_ADDR = 8'hC0;
   localparam int         TXC_BIT    = 6;

   localparam logic [2:0] CS_5BIT = 3'b000;
   localparam logic [2:0] CS_6BIT = 3'b001;
   localparam logic [2:0] CS_7BIT = 3'b010;
   localparam logic [2:0] CS_8BIT = 3'b011;
   localparam logic [2:0] CS_9BIT = 3'b111;

   localparam logic [1:0] UPM_NONE = 2'b00;
   localparam logic [1:0] UPM_EVEN = 2'b10;
   localparam logic [1:0] UPM_ODD  = 2'b11;

   localparam logic [3:0] TICKS_NORMAL_MAX = 4'd15;
   localparam logic [3:0] TICKS_DOUBLE_MAX = 4'd7;

   // Reserved size codes fall back to 8 bits; the 9-bit code only yields
   // 9 bits when the datapath was built wide enough to carry bit 8.
   function automatic logic [3:0] char_bits(input logic [2:0] cs, input logic nine_en);
      logic [3:0] n;
      case (cs)
         CS_5BIT: n = 4'd5;
         CS_6BIT: n = 4'd6;
         CS_7BIT: n = 4'd7;
         CS_8BIT: n = 4'd8;
         CS_9BIT: n = nine_en ? 4'd9 : 4'd8;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/usart_transmitter_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// tx_bit_timer
// Oversample tick counter that marks the end of each serial bit period.
// Counts baud_tick pulses 0..15 (0..7 in double-speed mode) while the
// transmitter is busy and flags the last tick of the period.
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   baud_tick in   one-clk oversample tick
//   run       in   transmitter busy; counter is held at zero otherwise
//   u2x       in   double speed (8 ticks per bit instead of 16)
//   bit_done  out  one-clk pulse on the tick that ends the current bit
// ---------------------------------------------------------------------------
module tx_bit_timer
   import usart_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic baud_tick,
   input  logic run,
   input  logic u2x,
   output logic bit_done
);

   logic [3:0] tick_cnt;
   logic [3:0] tick_max;

   // Bit period length depends on the speed mode latched at frame load.
   assign tick_max = u2x ? TICKS_DOUBLE_MAX : TICKS_NORMAL_MAX;

   // The bit ends during the cycle in which the counter already sits at its
   // maximum and another tick arrives; the FSM moves on at that same edge.
   assign bit_done = run && baud_tick && (tick_cnt == tick_max);

   // Tick counter: held at zero while idle so that the first bit after a
   // load always gets a full period; wraps to zero at every bit boundary
   // so back-to-back frames need no extra clear.
   always_ff @(posedge clk) begin
      if (!rst_n || !run) begin
         tick_cnt <= 4'd0;
      end else if (bit_done) begin
         tick_cnt <= 4'd0;
      end else if (baud_tick) begin
         tick_cnt <= tick_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/usart_transmitter.sv
// ---------------------------------------------------------------------------
// usart_transmitter
// Transmit half of USART0. Accepts bytes written to UDR (0xC6), holds one
// byte in a buffer, and serialises it onto sout as an asynchronous frame:
// start bit, 5..9 data bits LSB first, optional parity, one or two stop bits.
//
// Build option: define USART_TX_9BIT_EN to widen the buffer and shift
// register to 9 bits so cs=111 sends txb8 as data bit 8. Without it txb8 is
// ignored and cs=111 sends 8 bits.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   baud_tick in   oversample tick (16x baud, 8x when u2xn)
//   txen      in   transmitter enable (gates buffer writes only)
//   u2xn      in   double speed
//   upmn[1:0] in   parity mode: 0x none, 10 even, 11 odd
//   usbs      in   0 one stop bit, 1 two stop bits
//   cs[2:0]   in   character size code
//   addr[7:0] in   register address
//   write     in   write strobe
//   wdata[7:0]in   write data
//   txb8      in   9th data bit, captured with the UDR write
//   txcack    in   TXC acknowledge
//   sout      out  serial line, registered, idle high
//   udre      out  data buffer empty
//   txc       out  transmit complete
//   tx_busy   out  shift FSM not idle
// ---------------------------------------------------------------------------
module usart_transmitter
   import usart_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick,
   input  logic       txen,
   input  logic       u2xn,
   input  logic [1:0] upmn,
   input  logic       usbs,
   input  logic [2:0] cs,
   input  logic [7:0] addr,
   input  logic       write,
   input  logic [7:0] wdata,
   input  logic       txb8,
   input  logic       txcack,
   output logic       sout,
   output logic       udre,
   output logic       txc,
   output logic       tx_busy
);

`ifdef USART_TX_9BIT_EN
   localparam int   DW      = 9;
   localparam logic NINE_EN = 1'b1;
`else
   localparam int   DW      = 8;
   localparam logic NINE_EN = 1'b0;
`endif

   tx_state_t     state;
   tx_state_t     state_next;

   logic [DW-1:0] tx_buf;
   logic [DW-1:0] wr_word;
   logic [DW-1:0] shift_reg;
   logic [DW-1:0] shift_next;
   logic [3:0]    bit_idx;
   logic [3:0]    bit_idx_next;
   logic          sout_q;
   logic          sout_next;
   logic          udre_q;
   logic          txc_q;

   logic [3:0]    nbits_lat;
   logic          parity_en_lat;
   logic          parity_bit;
   logic          two_stop_lat;
   logic          u2x_lat;

   logic [3:0]    load_nbits;
   logic          load_parity;

   logic          bit_done;
   logic          busy;
   logic          buf_wr;
   logic          load;
   logic          last_stop;
   logic          txc_set;
   logic          txc_clr;

`ifdef USART_TX_9BIT_EN
   assign wr_word = {txb8, wdata};
`else
   logic unused_txb8;
   assign unused_txb8 = txb8;
   assign wr_word     = wdata;
`endif

   assign busy = (state != TX_IDLE);

   tx_bit_timer u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_tick (baud_tick),
      .run       (busy),
      .u2x       (u2x_lat),
      .bit_done  (bit_done)
   );

   // A UDR write is only taken when the transmitter is enabled and the
   // buffer is empty; anything else is silently dropped. TXC can be cleared
   // by the interrupt acknowledge or by writing a one to its UCSRA bit.
   assign buf_wr  = write && (addr == UDR_ADDR) && txen && udre_q;
   assign txc_clr = txcack || (write && (addr == UCSRA_ADDR) && wdata[TXC_BIT]);

   // Frame settings and parity are captured from the live inputs at load
   // time. Parity covers only the data bits that will actually be sent,
   // and starts from one for odd parity so the XOR chain yields the
   // inverted value.
   always_comb begin
      load_nbits  = char_bits(cs, NINE_EN);
      load_parity = upmn[0];
      for (int i = 0; i < DW; i++) begin
         if (i < int'(load_nbits)) begin
            load_parity = load_parity ^ tx_buf[i];
         end
      end
   end

   // Next-state and next-output logic for the shift FSM. The serial line is
   // registered, so sout_next is the value the line takes after the edge.
   // A load either starts from idle or overrides the end of the final stop
   // bit, which is what makes back-to-back frames gapless.
   always_comb begin
      state_next   = state;
      shift_next   = shift_reg;
      bit_idx_next = bit_idx;
      sout_next    = sout_q;
      last_stop    = 1'b0;

      if (bit_done && ((state == TX_STOP2) || ((state == TX_STOP1) && !two_stop_lat))) begin
         last_stop = 1'b1;
      end

      load = !udre_q && ((state == TX_IDLE) || last_stop);

      case (state)
         TX_IDLE: begin
            sout_next = 1'b1;
         end
         TX_START: begin
            if (bit_done) begin
               state_next = TX_DATA;
               sout_next  = shift_reg[0];
            end
         end
         TX_DATA: begin
            if (bit_done) begin
               if (bit_idx == (nbits_lat - 4'd1)) begin
                  state_next = parity_en_lat ? TX_PARITY : TX_STOP1;
                  sout_next  = parity_en_lat ? parity_bit : 1'b1;
               end else begin
                  shift_next   = shift_reg >> 1;
                  bit_idx_next = bit_idx + 4'd1;
                  sout_next    = shift_next[0];
               end
            end
         end
         TX_PARITY: begin
            if (bit_done) begin
               state_next = TX_STOP1;
               sout_next  = 1'b1;
            end
         end
         TX_STOP1: begin
            if (bit_done) begin
               state_next = two_stop_lat ? TX_STOP2 : TX_IDLE;
               sout_next  = 1'b1;
            end
         end
         TX_STOP2: begin
            if (bit_done) begin
               state_next = TX_IDLE;
               sout_next  = 1'b1;
            end
         end
         default: begin
            state_next = TX_IDLE;
            sout_next  = 1'b1;
         end
      endcase

      if (load) begin
         state_next   = TX_START;
         shift_next   = tx_buf;
         bit_idx_next = 4'd0;
         sout_next    = 1'b0;
      end
   end

   // TXC is raised when the last stop bit ends with nothing waiting in the
   // buffer; if there is a buffered byte the load takes over instead.
   assign txc_set = last_stop && udre_q;

   // Shift FSM state register together with its datapath: the shift
   // register, the data-bit index and the registered serial line. A reset
   // in the middle of a frame abandons it and returns the line to idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= TX_IDLE;
         shift_reg <= '0;
         bit_idx   <= 4'd0;
         sout_q    <= 1'b1;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         bit_idx   <= bit_idx_next;
         sout_q    <= sout_next;
      end
   end

   // Buffer, status flags and the per-frame configuration latches. A write
   // and a load can never coincide because one needs the buffer empty and
   // the other needs it full. For TXC a simultaneous set and clear leaves
   // the flag set so a completion is never lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_buf        <= '0;
         udre_q        <= 1'b1;
         txc_q         <= 1'b0;
         nbits_lat     <= 4'd0;
         parity_en_lat <= 1'b0;
         parity_bit    <= 1'b0;
         two_stop_lat  <= 1'b0;
         u2x_lat       <= 1'b0;
      end else begin
         if (buf_wr) begin
            tx_buf <= wr_word;
            udre_q <= 1'b0;
         end else if (load) begin
            udre_q <= 1'b1;
         end

         if (load) begin
            nbits_lat     <= load_nbits;
            parity_en_lat <= upmn[1];
            parity_bit    <= load_parity;
            two_stop_lat  <= usbs;
            u2x_lat       <= u2xn;
         end

         if (txc_set) begin
            txc_q <= 1'b1;
         end else if (txc_clr) begin
            txc_q <= 1'b0;
         end
      end
   end

   assign sout    = sout_q;
   assign udre    = udre_q;
   assign txc     = txc_q;
   assign tx_busy = busy;

endmodule

// File: tb/tb_usart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_usart_transmitter
// Self-checking bench for usart_transmitter. Table vectors carry hand-derived
// serial frames; random frames are checked against a bit-list model built
// directly from the frame format rules. Honours USART_TX_9BIT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usart_transmitter;

   localparam logic [7:0] TB_UDR   = 8'hC6;
   localparam logic [7:0] TB_UCSRA = 8'hC0;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick = 1'b0;
   logic       txen;
   logic       u2xn;
   logic [1:0] upmn;
   logic       usbs;
   logic [2:0] cs;
   logic [7:0] addr;
   logic       write;
   logic [7:0] wdata;
   logic       txb8;
   logic       txcack;
   logic       sout;
   logic       udre;
   logic       txc;
   logic       tx_busy;

   int checks = 0;
   int errors = 0;
   int tickDiv = 1;
   int tickPhase = 0;
   bit expBits[$];

   typedef struct {
      string      name;
      logic [2:0] cs;
      logic [1:0] upmn;
      logic       usbs;
      logic       u2xn;
      logic       txb8;
      logic [7:0] data;
      int         div;
      string      frame;
   } tableVec_t;

   tableVec_t vecs[7];

   usart_transmitter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_tick (baud_tick),
      .txen      (txen),
      .u2xn      (u2xn),
      .upmn      (upmn),
      .usbs      (usbs),
      .cs        (cs),
      .addr      (addr),
      .write     (write),
      .wdata     (wdata),
      .txb8      (txb8),
      .txcack    (txcack),
      .sout      (sout),
      .udre      (udre),
      .txc       (txc),
      .tx_busy   (tx_busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Oversample tick generator: one pulse every tickDiv clocks, updated on
   // the falling edge so the DUT sees a stable value at the rising edge.
   always @(negedge clk) begin
      tickPhase = tickPhase + 1;
      baud_tick = (tickDiv <= 1) || ((tickPhase % tickDiv) == 0);
   end

   // Global run-time bound.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic tableVec_t mkVec(input string n, input logic [2:0] c, input logic [1:0] p,
                                       input logic s, input logic x, input logic b8,
                                       input logic [7:0] d, input int dv, input string f);
      tableVec_t v;
      v.name = n; v.cs = c; v.upmn = p; v.usbs = s; v.u2xn = x;
      v.txb8 = b8; v.data = d; v.div = dv; v.frame = f;
      return v;
   endfunction

   function automatic int charBits(input logic [2:0] c);
      case (c)
         3'b000: return 5;
         3'b001: return 6;
         3'b010: return 7;
         3'b011: return 8;
`ifdef USART_TX_9BIT_EN
         3'b111: return 9;
`endif
         default: return 8;
      endcase
   endfunction

   // Reference model: append the frame the line should carry for one byte.
   task automatic modelFrame(input logic [2:0] c, input logic [1:0] p, input logic s,
                             input logic b8, input logic [7:0] d);
      logic [8:0] word;
      bit par;
      word = {b8, d};
      par  = p[0];
      expBits.push_back(1'b0);
      for (int i = 0; i < charBits(c); i++) begin
         expBits.push_back(word[i]);
         par = par ^ word[i];
      end
      if (p[1]) expBits.push_back(par);
      expBits.push_back(1'b1);
      if (s) expBits.push_back(1'b1);
   endtask

   task automatic pushString(input string f);
      for (int k = 0; k < f.len(); k++) begin
         expBits.push_back(f[k] == 8'd49);
      end
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] c, input logic [1:0] p, input logic s,
                                input logic x, input logic b8, input int dv);
      cs = c; upmn = p; usbs = s; u2xn = x; txb8 = b8; tickDiv = dv;
   endtask

   // One-cycle register write; returns at the falling edge of the cycle
   // after the write was sampled.
   task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; wdata = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   // Walk the expected bit list: each bit must hold for tpb sampled ticks.
   // Called at the falling edge before the first start-bit cycle; returns at
   // the falling edge right after the final stop bit ended.
   task automatic checkFrame(input string name, input int tpb, input bit checkLoad);
      int idx;
      int ticks;
      int cycles;
      int limit;
      bit bad;
      idx = 0; ticks = 0; cycles = 0; bad = 0;
      limit = expBits.size() * tpb * (tickDiv + 1) + 20;
      @(negedge clk);
      if (checkLoad) begin
         checkOutput({name, "_udre_at_load"}, udre, 1'b1);
         checkOutput({name, "_busy_at_load"}, tx_busy, 1'b1);
      end
      while ((idx < expBits.size()) && !bad) begin
         if (sout !== expBits[idx]) begin
            bad = 1;
            $display("[TB] FAIL %s: bit %0d after %0d ticks sout=%b, expected %b", name, idx, ticks, sout, expBits[idx]);
         end else begin
            @(posedge clk);
            if (baud_tick) ticks++;
            if (ticks == tpb) begin
               ticks = 0;
               idx++;
            end
            @(negedge clk);
            cycles++;
            if (cycles > limit) begin
               bad = 1;
               $display("[TB] FAIL %s_timeout: stuck at bit %0d, expected frame end within %0d cycles", name, idx, limit);
            end
         end
      end
      checks++;
      if (bad) errors++;
   endtask

   task automatic checkIdle(input string name, input int n);
      bit ok;
      ok = 1;
      repeat (n) begin
         @(negedge clk);
         if (sout !== 1'b1 || tx_busy !== 1'b0) ok = 0;
      end
      checkOutput(name, {15'd0, ok}, 16'd1);
   endtask

   initial begin
      logic [2:0] csChoices[5];
      csChoices[0] = 3'b000; csChoices[1] = 3'b001; csChoices[2] = 3'b010;
      csChoices[3] = 3'b011; csChoices[4] = 3'b111;

      vecs[0] = mkVec("8N1_A5",     3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 8'hA5, 1, "0101001011");
      vecs[1] = mkVec("8E2_A5_u2x", 3'b011, 2'b10, 1'b1, 1'b1, 1'b0, 8'hA5, 1, "010100101011");
      vecs[2] = mkVec("7O1_03",     3'b010, 2'b11, 1'b0, 1'b0, 1'b0, 8'h03, 1, "0110000011");
      vecs[3] = mkVec("5N1_F3",     3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 8'hF3, 2, "0110011");
      vecs[4] = mkVec("6O2_2A",     3'b001, 2'b11, 1'b1, 1'b0, 1'b0, 8'h2A, 1, "0010101011");
      vecs[5] = mkVec("5E1_07_div3",3'b000, 2'b10, 1'b0, 1'b1, 1'b0, 8'h07, 3, "01110011");
`ifdef USART_TX_9BIT_EN
      vecs[6] = mkVec("9bit_00",    3'b111, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 1, "00000000011");
`else
      vecs[6] = mkVec("9bit_00",    3'b111, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 1, "0000000001");
`endif

      rst_n = 1'b0; txen = 1'b1; write = 1'b0; addr = 8'h00; wdata = 8'h00; txcack = 1'b0;
      applyStimulus(3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 1);
      repeat (3) @(negedge clk);
      checkOutput("reset_sout", sout, 1'b1);
      checkOutput("reset_udre", udre, 1'b1);
      checkOutput("reset_txc", txc, 1'b0);
      checkOutput("reset_busy", tx_busy, 1'b0);
      rst_n = 1'b1;

      // Table-driven frames.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].cs, vecs[i].upmn, vecs[i].usbs, vecs[i].u2xn, vecs[i].txb8, vecs[i].div);
         expBits.delete();
         pushString(vecs[i].frame);
         busWrite(TB_UDR, vecs[i].data);
         checkOutput({vecs[i].name, "_udre_after_write"}, udre, 1'b0);
         checkOutput({vecs[i].name, "_sout_before_load"}, sout, 1'b1);
         checkFrame(vecs[i].name, vecs[i].u2xn ? 8 : 16, 1'b1);
         checkOutput({vecs[i].name, "_txc"}, txc, 1'b1);
         checkOutput({vecs[i].name, "_busy_end"}, tx_busy, 1'b0);
         if (i == 0) begin
            busWrite(TB_UCSRA, 8'hBF);
            checkOutput("ucsra_bit6_zero_keeps_txc", txc, 1'b1);
         end
         if (i % 2 == 1) begin
            busWrite(TB_UCSRA, 8'h40);
         end else begin
            @(negedge clk); txcack = 1'b1;
            @(negedge clk); txcack = 1'b0;
         end
         checkOutput({vecs[i].name, "_txc_cleared"}, txc, 1'b0);
      end

      // Back-to-back frames, a dropped third write, contiguous output.
      applyStimulus(3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 1);
      expBits.delete();
      pushString("0101010101");
      pushString("0010101011");
      busWrite(TB_UDR, 8'h55);
      fork
         checkFrame("b2b", 16, 1'b1);
         begin
            busWrite(TB_UDR, 8'hAA);
            checkOutput("b2b_second_accepted", udre, 1'b0);
            busWrite(TB_UDR, 8'h3C);
            checkOutput("b2b_third_dropped_udre", udre, 1'b0);
            repeat (100) @(negedge clk);
            checkOutput("b2b_no_txc_between", txc, 1'b0);
         end
      join
      checkOutput("b2b_txc", txc, 1'b1);
      checkIdle("b2b_no_third_frame", 60);
      busWrite(TB_UCSRA, 8'h40);

      // Disabled transmitter drops writes.
      txen = 1'b0;
      busWrite(TB_UDR, 8'h11);
      checkOutput("txen_off_udre", udre, 1'b1);
      checkIdle("txen_off_idle", 5);
      txen = 1'b1;

      // Disable mid-frame: current and buffered frames still complete.
      expBits.delete();
      pushString("0111100001");
      pushString("0000011111");
      busWrite(TB_UDR, 8'h0F);
      fork
         checkFrame("txen_mid", 16, 1'b0);
         begin
            busWrite(TB_UDR, 8'hF0);
            txen = 1'b0;
            repeat (170) @(negedge clk);
            busWrite(TB_UDR, 8'h99);
            checkOutput("txen_mid_drop_udre", udre, 1'b1);
         end
      join
      txen = 1'b1;
      checkOutput("txen_mid_txc", txc, 1'b1);

      // Acknowledge coincident with completion: set wins, then clears.
      busWrite(TB_UCSRA, 8'h40);
      txcack = 1'b1;
      expBits.delete();
      pushString("0100000011");
      busWrite(TB_UDR, 8'h81);
      checkFrame("ack_race", 16, 1'b0);
      checkOutput("txc_set_wins", txc, 1'b1);
      @(negedge clk);
      checkOutput("txc_ack_clears", txc, 1'b0);
      txcack = 1'b0;

      // Mid-frame reset with TXC set and a byte buffered.
      busWrite(TB_UDR, 8'h81);
      repeat (200) @(negedge clk);
      checkOutput("pre_reset_txc", txc, 1'b1);
      busWrite(TB_UDR, 8'h00);
      repeat (2) @(negedge clk);
      busWrite(TB_UDR, 8'h00);
      repeat (25) @(negedge clk);
      checkOutput("pre_reset_sout_low", sout, 1'b0);
      checkOutput("pre_reset_udre", udre, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset_sout", sout, 1'b1);
      checkOutput("midreset_udre", udre, 1'b1);
      checkOutput("midreset_txc", txc, 1'b0);
      checkOutput("midreset_busy", tx_busy, 1'b0);
      rst_n = 1'b1;
      checkIdle("post_reset_idle", 40);

      // Random frames against the model; configuration inputs are scrambled
      // mid-frame to confirm they only matter at load.
      for (int r = 0; r < 20; r++) begin
         logic [2:0] rc;
         logic [1:0] rp;
         logic rs, rx, rb;
         logic [7:0] rd;
         rc = csChoices[$urandom_range(0, 4)];
         rp = 2'($urandom_range(0, 3));
         rs = 1'($urandom_range(0, 1));
         rx = 1'($urandom_range(0, 1));
         rb = 1'($urandom_range(0, 1));
         rd = 8'($urandom);
         applyStimulus(rc, rp, rs, rx, rb, $urandom_range(1, 3));
         expBits.delete();
         modelFrame(rc, rp, rs, rb, rd);
         busWrite(TB_UDR, rd);
         fork
            checkFrame($sformatf("rand%0d", r), rx ? 8 : 16, 1'b1);
            begin
               repeat (20) @(negedge clk);
               cs   = csChoices[$urandom_range(0, 4)];
               upmn = 2'($urandom_range(0, 3));
               usbs = 1'($urandom_range(0, 1));
               u2xn = 1'($urandom_range(0, 1));
            end
         join
         checkOutput($sformatf("rand%0d_txc", r), txc, 1'b1);
         @(negedge clk); txcack = 1'b1;
         @(negedge clk); txcack = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
